// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between NUM_REQ requesters.
// The winner's operands feed the ALU combinationally. The result lands in a
// one-entry output register tagged with the winner's id. Both sides use
// valid/ready handshakes.
// Optional feature: define ALU_ARB_CNT_EN to add the saturating grant_cnt
// port, which counts accepted requests.

// Shared ALU, 4-bit op encoding:
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
//   Any other op returns 0.
module alu_arbiter_alu #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  // pure combinational op decode
  always_comb begin
    result = '0;
    case (op)
      4'd0: result = a + b;
      4'd1: result = a - b;
      4'd2: result = a & b;
      4'd3: result = a | b;
      4'd4: result = a ^ b;
      4'd5: result = a << sh;
      4'd6: result = a >> sh;
      4'd7: result = $signed(a) >>> sh;
      4'd8: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd9: result = {{(WIDTH-1){1'b0}}, a < b};
      default: result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [ID_W-1:0]          rsp_id
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [31:0]              grant_cnt
`endif
);
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rr_q, rr_d;

  logic [ID_W-1:0]  win;
  logic [ID_W:0]    idx;
  logic             found, can_accept, accept;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [3:0]       alu_op;

  // round-robin search: first valid index at or after rr_q, wrapping to 0
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  // The register can take a result when it is empty or draining this edge.
  // Grants are held off while reset is asserted.
  always_comb begin
    can_accept = (state_q == S_EMPTY) || rsp_ready;
    accept     = rst_n && found && can_accept;
    req_ready  = '0;
    if (rst_n && found) req_ready[win] = can_accept;
  end

  // operand mux feeding the single shared ALU
  always_comb begin
    alu_a  = req_a[win*WIDTH +: WIDTH];
    alu_b  = req_b[win*WIDTH +: WIDTH];
    alu_op = req_op[win*4 +: 4];
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res)
  );

  // output register state: EMPTY/FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // next state; a drain and a new accept on the same edge stay FULL
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (rsp_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM outputs
  always_comb begin
    rsp_valid  = (state_q == S_FULL);
    rsp_result = result_q;
    rsp_id     = id_q;
  end

  // Result/tag capture. Priority rotates only on an accept, so a stall
  // never rotates it.
  always_comb begin
    result_d = result_q;
    id_d     = id_q;
    rr_d     = rr_q;
    if (accept) begin
      result_d = alu_res;
      id_d     = win;
      rr_d     = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      id_q     <= '0;
      rr_q     <= '0;
    end else begin
      result_q <= result_d;
      id_q     <= id_d;
      rr_q     <= rr_d;
    end
  end

`ifdef ALU_ARB_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // saturating count of accepted requests
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  // counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
